// File: rtl/avm_pkg.sv
// Shared types and constants for the Avalon-MM command master.
package avm_pkg;

    localparam int AVM_ADDR_W = 8;
    localparam int AVM_DATA_W = 32;

    // Read data reported when a read is abandoned on waitrequest timeout.
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        RDLAT
    } avm_state_t;

endpackage

// File: rtl/avm_lat_counter.sv
// Loadable down-counter with a zero flag; reused for read latency and waitrequest timeout.
module avm_lat_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_in,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_value,
    output logic         zero
);

    logic [W-1:0] count;

    // Load wins over decrement; the count parks at zero.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/avm_cmd_master.sv
// Avalon-MM master running one read/write command at a time from a valid/ready port.
// Optional waitrequest timeout enabled by defining AVM_CMD_MASTER_TIMEOUT_EN.
module avm_cmd_master
    import avm_pkg::*;
#(
    parameter int ADDR_W         = AVM_ADDR_W,
    parameter int DATA_W         = AVM_DATA_W,
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_write,
    output logic [DATA_W-1:0] m_writedata,
    output logic              m_read,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_waitrequest
);

    avm_state_t        state, state_nxt;
    logic              cmd_ready_nxt;
    logic              rsp_valid_nxt, rsp_write_nxt, rsp_err_nxt;
    logic [DATA_W-1:0] rsp_rdata_nxt;
    logic [ADDR_W-1:0] m_address_nxt;
    logic [DATA_W-1:0] m_writedata_nxt;
    logic              m_write_nxt, m_read_nxt;
    logic              lat_load, lat_dec, lat_zero;

    avm_lat_counter #(.W(3)) u_lat_cnt (
        .clk        (clk),
        .rst_in     (rst_in),
        .load       (lat_load),
        .dec        (lat_dec),
        .load_value (3'(READ_LATENCY - 1)),
        .zero       (lat_zero)
    );

`ifdef AVM_CMD_MASTER_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic tmo_load, tmo_dec, tmo_zero;

    avm_lat_counter #(.W(TMO_W)) u_tmo_cnt (
        .clk        (clk),
        .rst_in     (rst_in),
        .load       (tmo_load),
        .dec        (tmo_dec),
        .load_value (TMO_W'(TIMEOUT_CYCLES - 1)),
        .zero       (tmo_zero)
    );
`endif

    // All outputs are registered; this block only computes their next values.
    always_comb begin
        state_nxt       = state;
        cmd_ready_nxt   = cmd_ready;
        rsp_valid_nxt   = 1'b0;
        rsp_write_nxt   = 1'b0;
        rsp_err_nxt     = 1'b0;
        rsp_rdata_nxt   = rsp_rdata;
        m_address_nxt   = m_address;
        m_writedata_nxt = m_writedata;
        m_write_nxt     = m_write;
        m_read_nxt      = m_read;
        lat_load        = 1'b0;
        lat_dec         = 1'b0;
`ifdef AVM_CMD_MASTER_TIMEOUT_EN
        tmo_load        = 1'b0;
        tmo_dec         = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    m_address_nxt   = cmd_addr;
                    m_writedata_nxt = cmd_wdata;
                    m_write_nxt     = cmd_write;
                    m_read_nxt      = !cmd_write;
                    cmd_ready_nxt   = 1'b0;
                    state_nxt       = cmd_write ? WR : RD;
`ifdef AVM_CMD_MASTER_TIMEOUT_EN
                    tmo_load        = 1'b1;
`endif
                end
            end
            WR: begin
                if (!m_waitrequest) begin
                    m_write_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_write_nxt = 1'b1;
                    cmd_ready_nxt = 1'b1;
                    state_nxt     = IDLE;
                end
`ifdef AVM_CMD_MASTER_TIMEOUT_EN
                else if (tmo_zero) begin
                    m_write_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_write_nxt = 1'b1;
                    rsp_err_nxt   = 1'b1;
                    cmd_ready_nxt = 1'b1;
                    state_nxt     = IDLE;
                end else begin
                    tmo_dec = 1'b1;
                end
`endif
            end
            RD: begin
                if (!m_waitrequest) begin
                    m_read_nxt = 1'b0;
                    if (READ_LATENCY == 0) begin
                        rsp_rdata_nxt = m_readdata;
                        rsp_valid_nxt = 1'b1;
                        cmd_ready_nxt = 1'b1;
                        state_nxt     = IDLE;
                    end else begin
                        lat_load  = 1'b1;
                        state_nxt = RDLAT;
                    end
                end
`ifdef AVM_CMD_MASTER_TIMEOUT_EN
                else if (tmo_zero) begin
                    m_read_nxt    = 1'b0;
                    rsp_rdata_nxt = DATA_W'(TIMEOUT_RDATA);
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b1;
                    cmd_ready_nxt = 1'b1;
                    state_nxt     = IDLE;
                end else begin
                    tmo_dec = 1'b1;
                end
`endif
            end
            RDLAT: begin
                if (lat_zero) begin
                    rsp_rdata_nxt = m_readdata;
                    rsp_valid_nxt = 1'b1;
                    cmd_ready_nxt = 1'b1;
                    state_nxt     = IDLE;
                end else begin
                    lat_dec = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_write   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
            m_address   <= '0;
            m_writedata <= '0;
            m_write     <= 1'b0;
            m_read      <= 1'b0;
        end else begin
            state       <= state_nxt;
            cmd_ready   <= cmd_ready_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_write   <= rsp_write_nxt;
            rsp_err     <= rsp_err_nxt;
            rsp_rdata   <= rsp_rdata_nxt;
            m_address   <= m_address_nxt;
            m_writedata <= m_writedata_nxt;
            m_write     <= m_write_nxt;
            m_read      <= m_read_nxt;
        end
    end

endmodule

// File: tb/tb_avm_cmd_master.sv
// Directed bench for avm_cmd_master with a response scoreboard checked on every rsp_valid.
module tb_avm_cmd_master;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int READ_LATENCY = 1;
    localparam int TIMEOUT_CYCLES = 8;
    localparam logic [31:0] JUNK = 32'h5A5A_A5A5;

    logic              clk = 1'b0;
    logic              rst_in;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] m_address;
    logic              m_write;
    logic [DATA_W-1:0] m_writedata;
    logic              m_read;
    logic [DATA_W-1:0] m_readdata;
    logic              m_waitrequest;

    typedef struct {
        logic        write;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [31:0] model_rdata = '0;
    int          total = 0;
    int          bad = 0;

    avm_cmd_master #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .READ_LATENCY   (READ_LATENCY),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk           (clk),
        .rst_in        (rst_in),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_write     (rsp_write),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .m_address     (m_address),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_read        (m_read),
        .m_readdata    (m_readdata),
        .m_waitrequest (m_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic write,
                                 input logic [7:0] addr, input logic [31:0] wdata);
        cmd_valid = valid;
        cmd_write = write;
        cmd_addr  = addr;
        cmd_wdata = wdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic pushExpected(input logic write, input logic [31:0] rdata, input logic err);
        rsp_t e;
        e.write = write;
        e.rdata = rdata;
        e.err   = err;
        exp_q.push_back(e);
    endtask

    // Every completion pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $error("[TB] FAIL rsp_unexpected: observed rsp_valid=1 expected no response");
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                assert (rsp_write === e.write && rsp_rdata === e.rdata && rsp_err === e.err)
                else begin
                    bad++;
                    $error("[TB] FAIL rsp_fields: observed w=%b d=%h e=%b expected w=%b d=%h e=%b",
                           rsp_write, rsp_rdata, rsp_err, e.write, e.rdata, e.err);
                end
            end
        end
    end

    initial begin
        rst_in        = 1'b1;
        m_waitrequest = 1'b0;
        m_readdata    = JUNK;
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0);
        repeat (3) tick();

        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst_m_write", 32'(m_write), 32'd0);
        checkOutput("rst_m_read", 32'(m_read), 32'd0);
        checkOutput("rst_m_address", 32'(m_address), 32'd0);
        checkOutput("rst_m_writedata", m_writedata, 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
        rst_in = 1'b0;
        tick();

        $display("[TB] single write, no wait");
        applyStimulus(1'b1, 1'b1, 8'h04, 32'h1234_5678);
        pushExpected(1'b1, model_rdata, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0);
        checkOutput("wr_m_write", 32'(m_write), 32'd1);
        checkOutput("wr_m_read", 32'(m_read), 32'd0);
        checkOutput("wr_m_address", 32'(m_address), 32'h04);
        checkOutput("wr_m_writedata", m_writedata, 32'h1234_5678);
        checkOutput("wr_cmd_ready_busy", 32'(cmd_ready), 32'd0);
        tick();
        checkOutput("wr_m_write_drop", 32'(m_write), 32'd0);
        checkOutput("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("wr_cmd_ready_back", 32'(cmd_ready), 32'd1);
        tick();

        $display("[TB] single read, latency 1");
        applyStimulus(1'b1, 1'b0, 8'h10, 32'h0);
        model_rdata = 32'hCAFE_F00D;
        pushExpected(1'b0, model_rdata, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0);
        checkOutput("rd_m_read", 32'(m_read), 32'd1);
        checkOutput("rd_m_write", 32'(m_write), 32'd0);
        checkOutput("rd_m_address", 32'(m_address), 32'h10);
        tick();
        m_readdata = 32'hCAFE_F00D;
        checkOutput("rd_m_read_drop", 32'(m_read), 32'd0);
        checkOutput("rd_lat_rsp_idle", 32'(rsp_valid), 32'd0);
        tick();
        m_readdata = JUNK;
        checkOutput("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("rd_cmd_ready_back", 32'(cmd_ready), 32'd1);
        tick();
        checkOutput("rd_rdata_held", rsp_rdata, 32'hCAFE_F00D);

        $display("[TB] write with 3-cycle waitrequest");
        m_waitrequest = 1'b1;
        applyStimulus(1'b1, 1'b1, 8'h20, 32'hA5A5_0001);
        pushExpected(1'b1, model_rdata, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 8'h77, 32'hFFFF_0000);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) m_waitrequest = 1'b0;
            checkOutput($sformatf("stall_m_write_%0d", i), 32'(m_write), 32'd1);
            checkOutput($sformatf("stall_m_address_%0d", i), 32'(m_address), 32'h20);
            checkOutput($sformatf("stall_m_writedata_%0d", i), m_writedata, 32'hA5A5_0001);
            checkOutput($sformatf("stall_cmd_ready_%0d", i), 32'(cmd_ready), 32'd0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0);
        checkOutput("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("stall_m_write_drop", 32'(m_write), 32'd0);
        tick();
        checkOutput("stall_no_second_cmd", 32'(m_write), 32'd0);

        $display("[TB] back-to-back read then write");
        applyStimulus(1'b1, 1'b0, 8'h00, 32'h0);
        model_rdata = 32'h1111_2222;
        pushExpected(1'b0, model_rdata, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 8'h01, 32'h3333_4444);
        pushExpected(1'b1, model_rdata, 1'b0);
        checkOutput("b2b_m_read", 32'(m_read), 32'd1);
        tick();
        m_readdata = 32'h1111_2222;
        tick();
        m_readdata = JUNK;
        checkOutput("b2b_rd_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("b2b_m_write_not_yet", 32'(m_write), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0);
        checkOutput("b2b_m_write", 32'(m_write), 32'd1);
        checkOutput("b2b_m_address", 32'(m_address), 32'h01);
        checkOutput("b2b_m_writedata", m_writedata, 32'h3333_4444);
        tick();
        checkOutput("b2b_wr_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("b2b_rdata_kept", rsp_rdata, 32'h1111_2222);
        tick();

        $display("[TB] reset during read stall");
        m_waitrequest = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h40, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0);
        checkOutput("rstmid_m_read", 32'(m_read), 32'd1);
        tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        model_rdata = '0;
        checkOutput("rstmid_m_read_drop", 32'(m_read), 32'd0);
        checkOutput("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
        m_waitrequest = 1'b0;
        repeat (2) tick();
        checkOutput("rstmid_still_idle", 32'(m_read), 32'd0);
        checkOutput("rstmid_rdata_cleared", rsp_rdata, 32'd0);

`ifdef AVM_CMD_MASTER_TIMEOUT_EN
        $display("[TB] read timeout");
        m_waitrequest = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h50, 32'h0);
        model_rdata = 32'hDEAD_BEEF;
        pushExpected(1'b0, model_rdata, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0);
        for (int i = 0; i < TIMEOUT_CYCLES; i++) begin
            checkOutput($sformatf("tmo_m_read_%0d", i), 32'(m_read), 32'd1);
            tick();
        end
        checkOutput("tmo_m_read_drop", 32'(m_read), 32'd0);
        checkOutput("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("tmo_rsp_err", 32'(rsp_err), 32'd1);
        m_waitrequest = 1'b0;
        tick();
        checkOutput("tmo_cmd_ready", 32'(cmd_ready), 32'd1);
`endif

        repeat (3) tick();
        checkOutput("pending_responses", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
